fp_special_case_stage: RTL and testbench

- Parametrised front-end special-case stage of the floating-point CORDIC pipeline.
- Classifies operands a/b/c (NaN, Inf, zero, denormal, normal) and selects the bypass/idle code and early result z/s.
- Unpacks operands to {sign, biased exp, hidden, mantissa} for the align stage.
- Adds valid/ready flow control with a 2-entry skid buffer, so pipeline back-pressure never drops an instruction.

---
 rtl/fp_special_pkg.sv | 38 +++
 rtl/fp_operand_classify.sv | 52 +++++
 rtl/fp_special_case_stage.sv | 197 +++++++++++++++++++
 tb/tb_fp_special_case_stage.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_special_pkg.sv
// Shared types and width helpers for the floating-point special-case front end.
package fp_special_pkg;

    typedef enum logic [1:0] {
        NO_IDLE     = 2'b00,
        ALLIGN_IDLE = 2'b01,
        PUT_IDLE    = 2'b10
    } idle_t;

    typedef enum logic [2:0] {
        NORM   = 3'd0,
        DENORM = 3'd1,
        ZERO   = 3'd2,
        INF    = 3'd3,
        NAN    = 3'd4
    } op_class_t;

    localparam int DEF_EXP_W   = 8;
    localparam int DEF_MAN_W   = 23;
    localparam int DEF_GUARD_W = 3;
    localparam int DEF_TAG_W   = 8;

    // IEEE packed operand: {sign, exp, man}
    function automatic int ieee_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Unpacked operand: {sign, exp, hidden, man}
    function automatic int unp_w(input int exp_w, input int man_w);
        return 2 + exp_w + man_w;
    endfunction

    // Unpacked operand with guard bits appended
    function automatic int unp_c_w(input int exp_w, input int man_w, input int guard_w);
        return 2 + exp_w + man_w + guard_w;
    endfunction

endpackage

// File: rtl/fp_operand_classify.sv
// Classifies one IEEE operand and unpacks it to {sign, exp, hidden, man}.
// Latency: combinational. Backpressure: none. FP_SPECIAL_FTZ_EN flushes denormals to signed zero.
module fp_operand_classify
    import fp_special_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    parameter bit IS_C  = 1'b0
) (
    input  logic [EXP_W+MAN_W:0]   operand,
    output op_class_t              op_class,
    output logic [EXP_W+MAN_W+1:0] unpacked
);

    logic             sign;
    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             hidden;

    always_comb begin
        sign  = operand[EXP_W+MAN_W];
        exp_f = operand[EXP_W+MAN_W-1:MAN_W];
        man_f = operand[MAN_W-1:0];

        if (&exp_f)
            op_class = (|man_f) ? NAN : INF;
        else if (exp_f == '0)
            op_class = (|man_f) ? DENORM : ZERO;
        else
            op_class = NORM;

`ifdef FP_SPECIAL_FTZ_EN
        if (op_class == DENORM) begin
            op_class = ZERO;
            man_f    = '0;
        end
`endif

        // The c operand only loses its hidden bit; a/b denormals also get the
        // minimum normal exponent so the aligner can treat them uniformly.
        hidden = 1'b1;
        if (IS_C) begin
            hidden = !(op_class == DENORM || op_class == ZERO);
        end else if (op_class == DENORM) begin
            hidden = 1'b0;
            exp_f  = {{(EXP_W-1){1'b0}}, 1'b1};
        end

        unpacked = {sign, exp_f, hidden, man_f};
    end

endmodule

// File: rtl/fp_special_case_stage.sv
// CORDIC front end: classifies a/b/c, picks idle code and early z/s, unpacks operands.
// Latency: 1 cycle accept-to-out_valid. Backpressure: 2-entry skid (output + skid reg), in_ready=~skid_full.
// Optional FP_SPECIAL_FTZ_EN: denormal operands are flushed to signed zero before classification.
module fp_special_case_stage
    import fp_special_pkg::*;
#(
    parameter int EXP_W   = DEF_EXP_W,
    parameter int MAN_W   = DEF_MAN_W,
    parameter int GUARD_W = DEF_GUARD_W,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [ieee_w(EXP_W,MAN_W)-1:0]     a_in,
    input  logic [ieee_w(EXP_W,MAN_W)-1:0]     b_in,
    input  logic [ieee_w(EXP_W,MAN_W)-1:0]     c_in,
    input  logic [1:0]                         mode_in,
    input  logic                               op_in,
    input  logic                               natlog_in,
    input  logic [TAG_W-1:0]                   tag_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [1:0]                         idle_out,
    output logic [unp_w(EXP_W,MAN_W)-1:0]      a_out,
    output logic [unp_w(EXP_W,MAN_W)-1:0]      b_out,
    output logic [unp_c_w(EXP_W,MAN_W,GUARD_W)-1:0] c_out,
    output logic [unp_c_w(EXP_W,MAN_W,GUARD_W)-1:0] z_out,
    output logic [ieee_w(EXP_W,MAN_W)-1:0]     s_out,
    output logic [1:0]                         mode_out,
    output logic                               op_out,
    output logic                               natlog_out,
    output logic [TAG_W-1:0]                   tag_out,
    output logic [5:0]                         class_out
);

    localparam int IEEE_W  = ieee_w(EXP_W, MAN_W);
    localparam int UNP_W   = unp_w(EXP_W, MAN_W);
    localparam int UNP_C_W = unp_c_w(EXP_W, MAN_W, GUARD_W);

    typedef struct packed {
        idle_t              idle;
        logic [UNP_W-1:0]   a;
        logic [UNP_W-1:0]   b;
        logic [UNP_C_W-1:0] c;
        logic [UNP_C_W-1:0] z;
        logic [IEEE_W-1:0]  s;
        logic [1:0]         mode;
        logic               op;
        logic               natlog;
        logic [TAG_W-1:0]   tag;
        logic [5:0]         cls;
    } beat_t;

    op_class_t          a_cls;
    op_class_t          b_cls;
    op_class_t          c_cls;
    logic [UNP_W-1:0]   a_unp;
    logic [UNP_W-1:0]   b_unp;
    logic [UNP_W-1:0]   c_unp;
    logic               c_cls_unused;

    fp_operand_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W), .IS_C(1'b0)) u_cls_a (
        .operand  (a_in),
        .op_class (a_cls),
        .unpacked (a_unp)
    );

    fp_operand_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W), .IS_C(1'b0)) u_cls_b (
        .operand  (b_in),
        .op_class (b_cls),
        .unpacked (b_unp)
    );

    fp_operand_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W), .IS_C(1'b1)) u_cls_c (
        .operand  (c_in),
        .op_class (c_cls),
        .unpacked (c_unp)
    );

    assign c_cls_unused = ^c_cls;

    // ---------------------------------------------------------------
    // Special-case decision for the incoming beat
    // ---------------------------------------------------------------
    beat_t              new_beat;
    logic               a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic               z_sign;
    logic [UNP_C_W-1:0] z_nan;
    logic [UNP_C_W-1:0] z_inf;
    logic [UNP_C_W-1:0] z_zero;

    always_comb begin
        a_nan  = (a_cls == NAN);
        a_inf  = (a_cls == INF);
        a_zero = (a_cls == ZERO);
        b_nan  = (b_cls == NAN);
        b_inf  = (b_cls == INF);
        b_zero = (b_cls == ZERO);
        z_sign = a_in[IEEE_W-1] ^ b_in[IEEE_W-1];

        z_nan  = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W+GUARD_W){1'b0}}};
        z_inf  = {z_sign, {EXP_W{1'b1}}, {(1+MAN_W+GUARD_W){1'b0}}};
        z_zero = {z_sign, {(UNP_C_W-1){1'b0}}};

        new_beat        = '0;
        new_beat.a      = a_unp;
        new_beat.b      = b_unp;
        new_beat.c      = {c_unp, {GUARD_W{1'b0}}};
        new_beat.mode   = mode_in;
        new_beat.op     = op_in;
        new_beat.natlog = natlog_in;
        new_beat.tag    = tag_in;
        new_beat.cls    = {a_nan, a_inf, a_zero, b_nan, b_inf, b_zero};
        new_beat.idle   = NO_IDLE;

        // Priority order matters: NaN beats Inf beats zero beats linear mode.
        if (a_nan || b_nan) begin
            new_beat.idle = ALLIGN_IDLE;
            new_beat.z    = z_nan;
        end else if (a_inf) begin
            new_beat.idle = ALLIGN_IDLE;
            new_beat.z    = b_zero ? z_nan : z_inf;
        end else if (b_inf) begin
            new_beat.idle = ALLIGN_IDLE;
            new_beat.z    = z_inf;
        end else if (a_zero || b_zero || mode_in == 2'b00) begin
            new_beat.idle = PUT_IDLE;
            new_beat.z    = z_zero;
            new_beat.s    = c_in;
        end
    end

    // ---------------------------------------------------------------
    // Output register plus one skid entry
    // ---------------------------------------------------------------
    beat_t out_q;
    beat_t skid_q;
    logic  skid_full;
    logic  skid_full_nxt;
    logic  accept;
    logic  out_free;

    assign accept   = in_valid & in_ready;
    assign out_free = ~out_valid | out_ready;

    always_comb begin
        skid_full_nxt = skid_full;
        if (out_free)
            skid_full_nxt = skid_full & accept;
        else if (accept)
            skid_full_nxt = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q     <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            skid_full <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            skid_full <= skid_full_nxt;
            in_ready  <= ~skid_full_nxt;
            if (out_free) begin
                // The older skid beat always leaves first to preserve order.
                if (skid_full) begin
                    out_q     <= skid_q;
                    out_valid <= 1'b1;
                    if (accept)
                        skid_q <= new_beat;
                end else if (accept) begin
                    out_q     <= new_beat;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_q <= new_beat;
            end
        end
    end

    assign idle_out   = out_q.idle;
    assign a_out      = out_q.a;
    assign b_out      = out_q.b;
    assign c_out      = out_q.c;
    assign z_out      = out_q.z;
    assign s_out      = out_q.s;
    assign mode_out   = out_q.mode;
    assign op_out     = out_q.op;
    assign natlog_out = out_q.natlog;
    assign tag_out    = out_q.tag;
    assign class_out  = out_q.cls;

endmodule

// File: tb/tb_fp_special_case_stage.sv
// Bench for fp_special_case_stage at default widths (FP_SPECIAL_FTZ_EN aware).
module tb_fp_special_case_stage;

    localparam int PERIOD = 10;
    localparam logic [35:0] NAN36 = 36'hFFC000000;
    localparam int C_NORM = 0, C_DEN = 1, C_ZERO = 2, C_INF = 3, C_NAN = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a_in = '0, b_in = '0, c_in = '0;
    logic [1:0]  mode_in = '0;
    logic        op_in = 1'b0, natlog_in = 1'b0;
    logic [7:0]  tag_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  idle_out;
    logic [32:0] a_out, b_out;
    logic [35:0] c_out, z_out;
    logic [31:0] s_out;
    logic [1:0]  mode_out;
    logic        op_out, natlog_out;
    logic [7:0]  tag_out;
    logic [5:0]  class_out;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0]  idle;
        logic [32:0] a;
        logic [32:0] b;
        logic [35:0] c;
        logic [35:0] z;
        logic [31:0] s;
        logic [1:0]  mode;
        logic        op;
        logic        nat;
        logic [7:0]  tag;
        logic [5:0]  cls;
    } ob_t;

    ob_t        expq[$];
    logic [7:0] popped[$];

    fp_special_case_stage dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .mode_in(mode_in), .op_in(op_in), .natlog_in(natlog_in), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .idle_out(idle_out), .a_out(a_out), .b_out(b_out), .c_out(c_out),
        .z_out(z_out), .s_out(s_out), .mode_out(mode_out), .op_out(op_out),
        .natlog_out(natlog_out), .tag_out(tag_out), .class_out(class_out)
    );

    always #(PERIOD/2) clock = ~clock;

    // ---------------- reference model ----------------
    function automatic int cls32(input logic [31:0] x);
        if (x[30:23] == 8'hFF) return (x[22:0] != 0) ? C_NAN : C_INF;
        if (x[30:23] == 8'h00) begin
            if (x[22:0] == 0) return C_ZERO;
`ifdef FP_SPECIAL_FTZ_EN
            return C_ZERO;
`else
            return C_DEN;
`endif
        end
        return C_NORM;
    endfunction

    function automatic logic [32:0] unp_ab(input logic [31:0] x);
        if (cls32(x) == C_DEN)   return {x[31], 8'd1, 1'b0, x[22:0]};
        if (cls32(x) == C_ZERO)  return {x[31], 8'd0, 1'b1, 23'd0};
        return {x[31], x[30:23], 1'b1, x[22:0]};
    endfunction

    function automatic logic [35:0] unp_c(input logic [31:0] x);
        int k = cls32(x);
        if (k == C_ZERO) return {x[31], 35'd0};
        if (k == C_DEN)  return {x[31], 8'd0, 1'b0, x[22:0], 3'b000};
        return {x[31], x[30:23], 1'b1, x[22:0], 3'b000};
    endfunction

    function automatic ob_t model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                  input logic [1:0] mode, input logic op, input logic nat,
                                  input logic [7:0] tag);
        ob_t  r;
        int   ka, kb;
        logic sx;
        r  = '0;
        ka = cls32(a);
        kb = cls32(b);
        sx = a[31] ^ b[31];
        r.a = unp_ab(a);
        r.b = unp_ab(b);
        r.c = unp_c(c);
        r.mode = mode; r.op = op; r.nat = nat; r.tag = tag;
        r.cls = {ka == C_NAN, ka == C_INF, ka == C_ZERO, kb == C_NAN, kb == C_INF, kb == C_ZERO};
        if (ka == C_NAN || kb == C_NAN) begin
            r.idle = 2'b01; r.z = NAN36;
        end else if (ka == C_INF) begin
            r.idle = 2'b01; r.z = (kb == C_ZERO) ? NAN36 : {sx, 8'hFF, 27'd0};
        end else if (kb == C_INF) begin
            r.idle = 2'b01; r.z = {sx, 8'hFF, 27'd0};
        end else if (ka == C_ZERO || kb == C_ZERO || mode == 2'b00) begin
            r.idle = 2'b10; r.z = {sx, 35'd0}; r.s = c;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clock) begin
        ob_t got;
        if (reset) begin
            expq.delete();
        end else begin
            if (expq.size() != 0 || out_valid) begin
                got = {idle_out, a_out, b_out, c_out, z_out, s_out, mode_out,
                       op_out, natlog_out, tag_out, class_out};
                total++;
                if (!out_valid) begin
                    bad++;
                    $display("FAIL sb_valid out_valid=0 pending=%0d", expq.size());
                end else if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL sb_spurious out_valid=1 tag=%0h none expected", tag_out);
                end else if (got !== expq[0]) begin
                    bad++;
                    $display("FAIL sb_beat got=%0h want=%0h", got, expq[0]);
                end
                if (out_valid && out_ready && expq.size() != 0) begin
                    popped.push_back(tag_out);
                    void'(expq.pop_front());
                end
            end
            if (in_valid && in_ready)
                expq.push_back(model(a_in, b_in, c_in, mode_in, op_in, natlog_in, tag_in));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [1:0] mode, input logic [7:0] tag);
        logic acc;
        a_in = a; b_in = b; c_in = c; mode_in = mode; tag_in = tag;
        op_in = tag[0]; natlog_in = tag[1];
        in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            if (acc) break;
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL accept_timeout tag=%0h got=no_accept want=accept", tag);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input logic [7:0] tag);
        logic seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (out_valid && tag_out == tag) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL out_timeout tag=%0h got=none want=beat", tag);
        end
    endtask

    logic [31:0] vals [10];
    logic        stream_done;
    longint      t0;

    initial begin
        vals = '{32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'h00000000, 32'h80000000,
                 32'h00000001, 32'h807FFFFF, 32'h3F800000, 32'hC0000000, 32'h42F6E979};

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_idle",      64'(idle_out),  64'd0);
        chk("rst_z",         64'(z_out),     64'd0);
        @(posedge clock); #1;

        // NaN on a
        send(32'h7FC00000, 32'h3F800000, 32'h0, 2'b01, 8'h01);
        wait_out(8'h01);
        chk("nan_idle",  64'(idle_out),  64'd1);
        chk("nan_z",     64'(z_out),     64'hFFC000000);
        chk("nan_s",     64'(s_out),     64'd0);
        chk("nan_class", 64'(class_out), 64'b100000);
        @(posedge clock); #1;

        // Inf times zero, Inf times negative
        send(32'h7F800000, 32'h00000000, 32'h0, 2'b01, 8'h02);
        wait_out(8'h02);
        chk("infzero_z", 64'(z_out), 64'hFFC000000);
        @(posedge clock); #1;
        send(32'h7F800000, 32'hBF800000, 32'h0, 2'b01, 8'h03);
        wait_out(8'h03);
        chk("infneg_idle", 64'(idle_out), 64'd1);
        chk("infneg_z",    64'(z_out),    64'hFF8000000);
        @(posedge clock); #1;

        // b Inf
        send(32'h3F800000, 32'hFF800000, 32'h0, 2'b01, 8'h04);
        wait_out(8'h04);
        chk("binf_z", 64'(z_out), 64'hFF8000000);
        @(posedge clock); #1;

        // zero a: put_idle, s = c
        send(32'h00000000, 32'h40000000, 32'h3F800000, 2'b00, 8'h5A);
        wait_out(8'h5A);
        chk("zero_idle", 64'(idle_out), 64'd2);
        chk("zero_z",    64'(z_out),    64'd0);
        chk("zero_s",    64'(s_out),    64'h3F800000);
        chk("zero_tag",  64'(tag_out),  64'h5A);
        chk("zero_c",    64'(c_out),    64'h3FC000000);
        @(posedge clock); #1;

        // linear mode, signed zero z
        send(32'hC0000000, 32'h3F800000, 32'h42F6E979, 2'b00, 8'h06);
        wait_out(8'h06);
        chk("lin_idle", 64'(idle_out), 64'd2);
        chk("lin_z",    64'(z_out),    64'h800000000);
        chk("lin_s",    64'(s_out),    64'h42F6E979);
        chk("lin_b",    64'(b_out),    64'h7F800000);
        @(posedge clock); #1;

        // normal/normal, non-linear: no_idle
        send(32'h3F800000, 32'h40000000, 32'h3F800000, 2'b01, 8'h07);
        wait_out(8'h07);
        chk("norm_idle", 64'(idle_out), 64'd0);
        chk("norm_s",    64'(s_out),    64'd0);
        @(posedge clock); #1;

        // denormal a
        send(32'h00000001, 32'h3F800000, 32'h0, 2'b01, 8'h08);
        wait_out(8'h08);
`ifdef FP_SPECIAL_FTZ_EN
        chk("den_idle", 64'(idle_out), 64'd2);
        chk("den_a",    64'(a_out),    64'h000800000);
`else
        chk("den_idle", 64'(idle_out), 64'd0);
        chk("den_a",    64'(a_out),    64'h001000001);
`endif
        @(posedge clock); #1;

        // full throughput: 6 back-to-back accepts in 6 cycles
        t0 = $time;
        for (int i = 0; i < 6; i++)
            send(vals[i], vals[9-i], vals[i+2], 2'(i), 8'(8'h30 + i));
        chk("thru_time", 64'($time - t0), 64'(6 * PERIOD));
        repeat (3) @(posedge clock);
        #1;

        // stall: out_ready low for 3 edges, 4 tagged beats, order kept
        popped.delete();
        out_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, 32'h0, 2'b01, 8'h00);
        send(32'h3F800000, 32'h40000000, 32'h0, 2'b01, 8'h01);
        @(negedge clock);
        chk("stall_in_ready", 64'(in_ready),  64'd0);
        chk("stall_tag_hold", 64'(tag_out),   64'h00);
        @(posedge clock); #1;
        fork
            send(32'h3F800000, 32'h40000000, 32'h0, 2'b01, 8'h02);
            begin
                @(posedge clock); #1;
                out_ready = 1'b1;
            end
        join
        send(32'h3F800000, 32'h40000000, 32'h0, 2'b01, 8'h03);
        repeat (4) @(posedge clock);
        #1;
        chk("stall_count", 64'(popped.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < popped.size())
                chk("stall_order", 64'(popped[i]), 64'(i));

        // randomised operand mix under random backpressure
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++)
                    send(vals[$urandom_range(0, 9)], vals[$urandom_range(0, 9)],
                         vals[$urandom_range(0, 9)], 2'($urandom_range(0, 3)), 8'(8'h80 + i));
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clock); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clock);
        #1;

        // reset with output valid and skid full
        out_ready = 1'b0;
        send(32'h7FC00000, 32'h3F800000, 32'h0, 2'b01, 8'h20);
        send(32'h7FC00000, 32'h3F800000, 32'h0, 2'b01, 8'h21);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_in_ready",  64'(in_ready),  64'd1);
        chk("mrst_idle",      64'(idle_out),  64'd0);
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #(PERIOD * 5000);
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
